// File: rtl/my_design_multi_pkg.sv
// Shared definitions for the multi-channel fabric-exercise design:
// o_DataOp mode encodings and delay-line sizing helper.
package my_design_pkg;

    localparam logic [1:0] MODE_INV     = 2'b00;
    localparam logic [1:0] MODE_XOR_DLY = 2'b01;
    localparam logic [1:0] MODE_AND_FF  = 2'b10;
    localparam logic [1:0] MODE_INV_FF  = 2'b11;

    // Fill counter must be able to represent the value DEPTH itself.
    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/my_design_multi_if.sv
// Data-path bundle of my_design_multi: stimulus inputs and the five
// observed resource outputs.
interface my_design_multi_if #(
    parameter int WIDTH       = 4,
    parameter int COUNT_WIDTH = 8
);
    logic [WIDTH-1:0]       i_Data;
    logic                   i_Enable;
    logic [1:0]             i_Mode;
    logic [WIDTH-1:0]       o_DataFF;
    logic [WIDTH-1:0]       o_DataPassthrough;
    logic [WIDTH-1:0]       o_DataOp;
    logic [WIDTH-1:0]       o_DataDelayed;
    logic                   o_Valid;
    logic                   o_Toggle;
    logic [COUNT_WIDTH-1:0] o_EdgeCount;

    modport master (
        output i_Data, i_Enable, i_Mode,
        input  o_DataFF, o_DataPassthrough, o_DataOp, o_DataDelayed,
               o_Valid, o_Toggle, o_EdgeCount
    );

    modport slave (
        input  i_Data, i_Enable, i_Mode,
        output o_DataFF, o_DataPassthrough, o_DataOp, o_DataDelayed,
               o_Valid, o_Toggle, o_EdgeCount
    );
endinterface

// File: rtl/my_design_multi_delay_line.sv
// Enable-gated DEPTH-stage shift register with a saturating fill counter
// that flags when every stage carries post-reset data.
module delay_line
    import my_design_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Enable,
    input  logic [WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Valid
);
    localparam int FILL_W = fill_width(DEPTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    if (DEPTH < 1 || WIDTH < 1) begin : g_bad_params
        $error("delay_line: DEPTH and WIDTH must both be at least 1");
    end

    logic [DEPTH-1:0][WIDTH-1:0] stage_reg;
    logic [DEPTH-1:0][WIDTH-1:0] stage_next;
    logic [FILL_W-1:0]           fill_reg;
    logic [FILL_W-1:0]           fill_next;
    logic                        valid_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_next[gi] = i_Data;
        end else begin : g_tail
            assign stage_next[gi] = stage_reg[gi-1];
        end
    end

    always_comb begin
        fill_next = fill_reg;
        if (i_Enable && fill_reg != FILL_MAX) begin
            fill_next = fill_reg + 1'b1;
        end
    end

    // Valid is registered alongside the counter so it rises with the first
    // post-reset sample leaving the last stage.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            stage_reg <= '0;
            fill_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            if (i_Enable) begin
                stage_reg <= stage_next;
            end
            fill_reg  <= fill_next;
            valid_reg <= (fill_next == FILL_MAX);
        end
    end

    assign o_Data  = stage_reg[DEPTH-1];
    assign o_Valid = valid_reg;

endmodule

// File: rtl/my_design_multi.sv
// Top level: one-cycle flop, passthrough, mode-selected op, gated delay
// line, free-running toggle and rising-edge counter on a WIDTH-bit bus.
module my_design_multi
    import my_design_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 3,
    parameter int COUNT_WIDTH = 8
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    my_design_multi_if.slave bus
);
    if (DEPTH < 1 || WIDTH < 1) begin : g_bad_params
        $error("my_design_multi: DEPTH and WIDTH must both be at least 1");
    end

    logic [WIDTH-1:0]       data_ff_reg;
    logic                   toggle_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic [WIDTH-1:0]       delayed;
    logic                   valid;
    logic [WIDTH-1:0]       data_op;
    logic                   rise;

    delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_delay_line (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Enable (bus.i_Enable),
        .i_Data   (bus.i_Data),
        .o_Data   (delayed),
        .o_Valid  (valid)
    );

    // The flop doubles as the previous sample of bit 0 for edge detection.
    assign rise = bus.i_Data[0] & ~data_ff_reg[0];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            data_ff_reg <= '0;
            toggle_reg  <= 1'b0;
            count_reg   <= '0;
        end else begin
            data_ff_reg <= bus.i_Data;
            toggle_reg  <= ~toggle_reg;
            if (rise) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    always_comb begin
        data_op = ~bus.i_Data;
        unique case (bus.i_Mode)
            MODE_INV:     data_op = ~bus.i_Data;
            MODE_XOR_DLY: data_op = bus.i_Data ^ delayed;
            MODE_AND_FF:  data_op = bus.i_Data & data_ff_reg;
            MODE_INV_FF:  data_op = ~data_ff_reg;
            default:      data_op = ~bus.i_Data;
        endcase
    end

    assign bus.o_DataFF          = data_ff_reg;
    assign bus.o_DataPassthrough = bus.i_Data;
    assign bus.o_DataOp          = data_op;
    assign bus.o_DataDelayed     = delayed;
    assign bus.o_Valid           = valid;
    assign bus.o_Toggle          = toggle_reg;
    assign bus.o_EdgeCount       = count_reg;

endmodule

// File: tb/tb_my_design_multi.sv
// Self-checking bench for my_design_multi (WIDTH=4, DEPTH=3, COUNT_WIDTH=2):
// vector table through a scoreboard queue, plus mode and counter-wrap sequences.
module tb_my_design_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    my_design_multi_if #(.WIDTH(4), .COUNT_WIDTH(2)) bus ();

    my_design_multi #(
        .WIDTH       (4),
        .DEPTH       (3),
        .COUNT_WIDTH (2)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [3:0] data;
        logic [3:0] ff;
        logic [3:0] dly;
        logic       valid;
        logic       tog;
        logic [1:0] cnt;
        logic [3:0] op;
    } vec_t;

    vec_t       tbl[$];
    vec_t       exp_q[$];
    logic [1:0] cnt_q[$];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [1:0] m, input logic [3:0] d,
                       input logic [3:0] ff, input logic [3:0] dly, input logic v, input logic t,
                       input logic [1:0] c, input logic [3:0] op);
        vec_t x;
        x.rst = r; x.en = e; x.mode = m; x.data = d;
        x.ff = ff; x.dly = dly; x.valid = v; x.tog = t; x.cnt = c; x.op = op;
        tbl.push_back(x);
    endtask

    // Drive inputs, take one rising edge, then settle 1ns past it.
    task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [3:0] d);
        rst          = r;
        bus.i_Enable = e;
        bus.i_Mode   = m;
        bus.i_Data   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       got;
        logic [3:0] mode_exp [4];
        logic [1:0] wrap_exp [5];
        logic [1:0] want;

        //   rst   en    mode   data   ff     dly    vld   tog   cnt    op
        // reset held 3 cycles with data F, enable high
        add(1'b1, 1'b1, 2'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
        add(1'b1, 1'b1, 2'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
        add(1'b1, 1'b1, 2'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
        // fill: 1 emerges three cycles after it is applied, valid with it
        add(1'b0, 1'b1, 2'd0, 4'h1, 4'h1, 4'h0, 1'b0, 1'b1, 2'd1, 4'hE);
        add(1'b0, 1'b1, 2'd0, 4'h2, 4'h2, 4'h0, 1'b0, 1'b0, 2'd1, 4'hD);
        add(1'b0, 1'b1, 2'd0, 4'h3, 4'h3, 4'h1, 1'b1, 1'b1, 2'd2, 4'hC);
        add(1'b0, 1'b1, 2'd0, 4'h4, 4'h4, 4'h2, 1'b1, 1'b0, 2'd2, 4'hB);
        // enable dropped 2 cycles: delayed output holds, valid stays
        add(1'b0, 1'b0, 2'd0, 4'h5, 4'h5, 4'h2, 1'b1, 1'b1, 2'd3, 4'hA);
        add(1'b0, 1'b0, 2'd0, 4'h6, 4'h6, 4'h2, 1'b1, 1'b0, 2'd3, 4'h9);
        add(1'b0, 1'b1, 2'd0, 4'h5, 4'h5, 4'h3, 1'b1, 1'b1, 2'd0, 4'hA);
        add(1'b0, 1'b1, 2'd3, 4'h6, 4'h6, 4'h4, 1'b1, 1'b0, 2'd0, 4'h9);
        add(1'b0, 1'b1, 2'd2, 4'h7, 4'h7, 4'h5, 1'b1, 1'b1, 2'd1, 4'h7);
        // mid-fill reset, then a fresh fill with one disabled cycle inside
        add(1'b1, 1'b1, 2'd0, 4'h8, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h7);
        add(1'b0, 1'b1, 2'd0, 4'h1, 4'h1, 4'h0, 1'b0, 1'b1, 2'd1, 4'hE);
        add(1'b0, 1'b1, 2'd0, 4'h2, 4'h2, 4'h0, 1'b0, 1'b0, 2'd1, 4'hD);
        add(1'b1, 1'b1, 2'd0, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'hC);
        add(1'b0, 1'b1, 2'd0, 4'h9, 4'h9, 4'h0, 1'b0, 1'b1, 2'd1, 4'h6);
        add(1'b0, 1'b1, 2'd0, 4'hA, 4'hA, 4'h0, 1'b0, 1'b0, 2'd1, 4'h5);
        add(1'b0, 1'b0, 2'd0, 4'hB, 4'hB, 4'h0, 1'b0, 1'b1, 2'd2, 4'h4);
        add(1'b0, 1'b1, 2'd1, 4'hC, 4'hC, 4'h9, 1'b1, 1'b0, 2'd2, 4'h5);
        // set up ff=6, delayed=3 for the mode sweep
        add(1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'hF);
        add(1'b0, 1'b1, 2'd0, 4'h3, 4'h3, 4'h0, 1'b0, 1'b1, 2'd1, 4'hC);
        add(1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1, 4'hF);
        add(1'b0, 1'b1, 2'd0, 4'h6, 4'h6, 4'h3, 1'b1, 1'b1, 2'd1, 4'h9);

        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i]);
            drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].data);
            got = exp_q.pop_front();
            check($sformatf("v%0d ff", i),    32'(bus.o_DataFF),          32'(got.ff));
            check($sformatf("v%0d dly", i),   32'(bus.o_DataDelayed),     32'(got.dly));
            check($sformatf("v%0d valid", i), 32'(bus.o_Valid),           32'(got.valid));
            check($sformatf("v%0d tog", i),   32'(bus.o_Toggle),          32'(got.tog));
            check($sformatf("v%0d cnt", i),   32'(bus.o_EdgeCount),       32'(got.cnt));
            check($sformatf("v%0d pass", i),  32'(bus.o_DataPassthrough), 32'(got.data));
            check($sformatf("v%0d op", i),    32'(bus.o_DataOp),          32'(got.op));
            $display("[TB] vec %0d rst=%0b en=%0b mode=%0d data=%h -> ff=%h dly=%h vld=%0b tog=%0b cnt=%0d op=%h",
                     i, got.rst, got.en, got.mode, got.data, bus.o_DataFF, bus.o_DataDelayed,
                     bus.o_Valid, bus.o_Toggle, bus.o_EdgeCount, bus.o_DataOp);
        end

        // Mode sweep with data=A against ff=6, delayed=3, no clock edge in between
        mode_exp[0] = 4'h5; mode_exp[1] = 4'h9; mode_exp[2] = 4'h2; mode_exp[3] = 4'h9;
        for (int m = 0; m < 4; m++) begin
            bus.i_Data = 4'hA;
            bus.i_Mode = 2'(m);
            #1;
            check($sformatf("mode%0d op", m), 32'(bus.o_DataOp), 32'(mode_exp[m]));
            $display("[TB] mode %0d data=A -> op=%h", m, bus.o_DataOp);
        end

        // Edge counter wrap at COUNT_WIDTH=2: five single-cycle pulses
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
        drive(1'b1, 1'b0, 2'd0, 4'h0);
        check("wrap reset cnt", 32'(bus.o_EdgeCount), 32'd0);
        for (int p = 0; p < 5; p++) begin
            cnt_q.push_back(wrap_exp[p]);
            drive(1'b0, 1'b0, 2'd0, 4'h1);
            want = cnt_q.pop_front();
            check($sformatf("pulse%0d high cnt", p), 32'(bus.o_EdgeCount), 32'(want));
            $display("[TB] pulse %0d high -> cnt=%0d", p, bus.o_EdgeCount);
            cnt_q.push_back(wrap_exp[p]);
            drive(1'b0, 1'b0, 2'd0, 4'h0);
            want = cnt_q.pop_front();
            check($sformatf("pulse%0d low cnt", p), 32'(bus.o_EdgeCount), 32'(want));
            $display("[TB] pulse %0d low -> cnt=%0d", p, bus.o_EdgeCount);
        end

        // A level held high for 4 cycles is one rising edge only
        for (int h = 0; h < 4; h++) begin
            cnt_q.push_back(2'd2);
            drive(1'b0, 1'b1, 2'd0, 4'h1);
            want = cnt_q.pop_front();
            check($sformatf("hold%0d cnt", h), 32'(bus.o_EdgeCount), 32'(want));
            $display("[TB] hold %0d -> cnt=%0d", h, bus.o_EdgeCount);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
